move_controller: RTL and testbench

MOVE_CONTROLLER -- requirements
Module: move_controller

---
 rtl/move_controller_pkg.sv | 44 ++++
 rtl/column_height_bank.sv | 46 ++++
 rtl/move_controller.sv | 148 ++++++++++++++
 tb/tb_move_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/move_controller_pkg.sv
// Shared definitions for the column-drop move controller.
//   - state_e       : controller FSM state encoding
//   - ColCode0..3   : the four legal active-low one-hot column codes
//   - HeightW, ColW : column height and column index widths
//   - decode_column : maps a raw column code to {valid, index}
package move_controller_pkg;

    localparam int unsigned HeightW = 3;
    localparam int unsigned ColW    = 2;

    localparam logic [3:0] ColCode0 = 4'b1110;
    localparam logic [3:0] ColCode1 = 4'b1101;
    localparam logic [3:0] ColCode2 = 4'b1011;
    localparam logic [3:0] ColCode3 = 4'b0111;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StPlace,
        StWaitRel,
        StFull
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ColW-1:0] idx;
    } col_sel_t;

    // Anything other than exactly one low bit is illegal, including 4'b1111.
    function automatic col_sel_t decode_column(input logic [3:0] code);
        col_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = '0;
        case (code)
            ColCode0: sel.idx = 2'd0;
            ColCode1: sel.idx = 2'd1;
            ColCode2: sel.idx = 2'd2;
            ColCode3: sel.idx = 2'd3;
            default:  sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/column_height_bank.sv
// Per-column height registers for the four board columns.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear of all heights
//   inc        : increment the height selected by inc_idx (saturates at ROWS)
//   inc_idx    : column to increment
//   rd_idx     : column to read
//   rd_height  : height of column rd_idx
//   count      : packed heights {h3, h2, h1, h0}
module column_height_bank
    import move_controller_pkg::*;
#(
    parameter int unsigned ROWS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [ColW-1:0]      inc_idx,
    input  logic [ColW-1:0]      rd_idx,
    output logic [HeightW-1:0]   rd_height,
    output logic [4*HeightW-1:0] count
);

    localparam logic [HeightW-1:0] RowsH = HeightW'(ROWS);

    logic [HeightW-1:0] height_q [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                height_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                height_q[i] <= '0;
            end
        end else if (inc && (height_q[inc_idx] != RowsH)) begin
            height_q[inc_idx] <= height_q[inc_idx] + HeightW'(1);
        end
    end

    assign rd_height = height_q[rd_idx];
    assign count     = {height_q[3], height_q[2], height_q[1], height_q[0]};

endmodule

// File: rtl/move_controller.sv
// Move controller for a four-column drop board: validates a held drop request,
// checks the target column has room, issues one board write per request,
// alternates players and latches board_full once every cell is placed.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   column, drop : active-low one-hot column select and held move request
//   place_*      : one-cycle board write (col, row, owning player)
//   reject       : one-cycle pulse for an illegal code or a full column
//   player       : player to move
//   count        : packed column heights {h3, h2, h1, h0}
//   board_full   : all ROWS*COLS cells placed
module move_controller
    import move_controller_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           column,
    input  logic                 drop,
    output logic                 place_we,
    output logic [ColW-1:0]      place_col,
    output logic [HeightW-1:0]   place_row,
    output logic                 place_player,
    output logic                 reject,
    output logic                 player,
    output logic [4*HeightW-1:0] count,
    output logic                 board_full
);

    localparam int unsigned        Cells  = ROWS * COLS;
    localparam int unsigned        TotalW = $clog2(Cells + 1);
    localparam logic [HeightW-1:0] RowsH  = HeightW'(ROWS);
    localparam logic [TotalW-1:0]  CellsT = TotalW'(Cells);

    state_e               state_q;
    logic [ColW-1:0]      col_q;
    logic [TotalW-1:0]    total_q;
    logic [TotalW-1:0]    total_inc;
    logic                 player_q;
    logic                 place_we_q;
    logic [ColW-1:0]      place_col_q;
    logic [HeightW-1:0]   place_row_q;
    logic                 place_player_q;
    logic                 reject_q;
    logic                 full_q;
    logic [HeightW-1:0]   cur_height;
    logic                 height_inc;
    col_sel_t             sel;

    assign sel        = decode_column(column);
    assign total_inc  = total_q + TotalW'(1);
    // Heights advance on the edge that leaves PLACE, alongside the player toggle.
    assign height_inc = (state_q == StPlace);

    column_height_bank #(
        .ROWS (ROWS)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .inc       (height_inc),
        .inc_idx   (col_q),
        .rd_idx    (col_q),
        .rd_height (cur_height),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            col_q          <= '0;
            total_q        <= '0;
            player_q       <= 1'b0;
            place_we_q     <= 1'b0;
            place_col_q    <= '0;
            place_row_q    <= '0;
            place_player_q <= 1'b0;
            reject_q       <= 1'b0;
            full_q         <= 1'b0;
        end else begin
            // Strobes and write fields default low so they read 0 outside PLACE.
            place_we_q     <= 1'b0;
            place_col_q    <= '0;
            place_row_q    <= '0;
            place_player_q <= 1'b0;
            reject_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (drop) begin
                        if (sel.valid) begin
                            col_q   <= sel.idx;
                            state_q <= StCheck;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= StWaitRel;
                        end
                    end
                end
                StCheck: begin
                    if (cur_height >= RowsH) begin
                        reject_q <= 1'b1;
                        state_q  <= StWaitRel;
                    end else begin
                        place_we_q     <= 1'b1;
                        place_col_q    <= col_q;
                        place_row_q    <= cur_height;
                        place_player_q <= player_q;
                        state_q        <= StPlace;
                    end
                end
                StPlace: begin
                    player_q <= ~player_q;
                    if (total_q != CellsT) begin
                        total_q <= total_inc;
                    end
                    if (total_inc == CellsT) begin
                        full_q  <= 1'b1;
                        state_q <= StFull;
                    end else begin
                        state_q <= StWaitRel;
                    end
                end
                StWaitRel: begin
                    if (!drop) begin
                        state_q <= StIdle;
                    end
                end
                StFull: begin
                    full_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign place_we     = place_we_q;
    assign place_col    = place_col_q;
    assign place_row    = place_row_q;
    assign place_player = place_player_q;
    assign reject       = reject_q;
    assign player       = player_q;
    assign board_full   = full_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: hand-computed expectations per scenario.
module tb_move_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  column;
    logic        drop;
    logic        place_we;
    logic [1:0]  place_col;
    logic [2:0]  place_row;
    logic        place_player;
    logic        reject;
    logic        player;
    logic [11:0] count;
    logic        board_full;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rej_cnt = 0;

    move_controller #(
        .ROWS (4),
        .COLS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .column       (column),
        .drop         (drop),
        .place_we     (place_we),
        .place_col    (place_col),
        .place_row    (place_row),
        .place_player (place_player),
        .reject       (reject),
        .player       (player),
        .count        (count),
        .board_full   (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally strobes mid-cycle so held-drop and FULL behaviour can be checked by count.
    always @(negedge clk) begin
        if (place_we) we_cnt++;
        if (reject) rej_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " outputs"},
                 {19'd0, place_we, place_col, place_row, place_player, reject, player,
                  board_full, 4'd0},
                 32'd0);
        check_eq({tag, " count"}, {20'd0, count}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Legal move: drop sampled at edge N, write visible after edge N+1.
    task automatic do_move(input logic [3:0] code, input int exp_col, input int exp_row,
                           input int exp_player);
        drop   = 1'b1;
        column = code;
        tick();
        check_eq("we_in_check", {31'd0, place_we}, 32'd0);
        tick();
        check_eq("we", {31'd0, place_we}, 32'd1);
        check_eq("col", {30'd0, place_col}, exp_col);
        check_eq("row", {29'd0, place_row}, exp_row);
        check_eq("pl", {31'd0, place_player}, exp_player);
        drop = 1'b0;
        tick();
        check_eq("we_after", {31'd0, place_we}, 32'd0);
        check_eq("fields_zero", {26'd0, place_col, place_row, place_player}, 32'd0);
        tick();
    endtask

    initial begin
        int base_we;
        int base_rej;
        column = 4'b1110;
        drop   = 1'b1;
        reset  = 1'b1;

        // Reset holds everything low even with drop asserted.
        tick();
        tick();
        tick();
        check_all_zero("reset");
        drop = 1'b0;
        reset = 1'b0;
        tick();

        // Scenario 1: held drop on col1 produces exactly one write.
        base_we = we_cnt;
        drop   = 1'b1;
        column = 4'b1101;
        tick();
        check_eq("s1_we_n1", {31'd0, place_we}, 32'd0);
        tick();
        check_eq("s1_we", {31'd0, place_we}, 32'd1);
        check_eq("s1_col", {30'd0, place_col}, 32'd1);
        check_eq("s1_row", {29'd0, place_row}, 32'd0);
        check_eq("s1_pl", {31'd0, place_player}, 32'd0);
        tick();
        check_eq("s1_count", {20'd0, count}, 32'h008);
        check_eq("s1_player", {31'd0, player}, 32'd1);
        tick();
        tick();
        check_eq("s1_one_write", we_cnt - base_we, 32'd1);
        drop = 1'b0;
        tick();
        tick();

        // Scenario 2: fill col0 then overflow it.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            do_move(4'b1110, 0, r, r % 2);
        end
        base_we = we_cnt;
        drop   = 1'b1;
        column = 4'b1110;
        tick();
        check_eq("s2_rej_n1", {31'd0, reject}, 32'd0);
        tick();
        check_eq("s2_rej_n2", {31'd0, reject}, 32'd1);
        check_eq("s2_we", {31'd0, place_we}, 32'd0);
        drop = 1'b0;
        tick();
        check_eq("s2_rej_pulse", {31'd0, reject}, 32'd0);
        tick();
        check_eq("s2_h0", {29'd0, count[2:0]}, 32'd4);
        check_eq("s2_player", {31'd0, player}, 32'd0);
        check_eq("s2_no_write", we_cnt - base_we, 32'd0);

        // Scenario 3: illegal codes reject one cycle after the sample.
        base_we = we_cnt;
        drop   = 1'b1;
        column = 4'b1100;
        tick();
        check_eq("s3a_rej", {31'd0, reject}, 32'd1);
        drop = 1'b0;
        tick();
        check_eq("s3a_rej_pulse", {31'd0, reject}, 32'd0);
        tick();
        drop   = 1'b1;
        column = 4'b1111;
        tick();
        check_eq("s3b_rej", {31'd0, reject}, 32'd1);
        drop = 1'b0;
        tick();
        tick();
        check_eq("s3_player", {31'd0, player}, 32'd0);
        check_eq("s3_no_write", we_cnt - base_we, 32'd0);
        check_eq("s3_count", {20'd0, count}, 32'h004);

        // Scenario 4: 16 moves fill the board.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [3:0] code;
                code = 4'b1111;
                code[c] = 1'b0;
                do_move(code, c, r, (c * 4 + r) % 2);
            end
        end
        check_eq("s4_full", {31'd0, board_full}, 32'd1);
        check_eq("s4_count", {20'd0, count}, 32'h924);
        base_we  = we_cnt;
        base_rej = rej_cnt;
        drop   = 1'b1;
        column = 4'b1101;
        for (int i = 0; i < 4; i++) tick();
        drop   = 1'b0;
        column = 4'b1100;
        tick();
        drop = 1'b1;
        tick();
        tick();
        drop = 1'b0;
        tick();
        check_eq("s4_no_we", we_cnt - base_we, 32'd0);
        check_eq("s4_no_rej", rej_cnt - base_rej, 32'd0);
        check_eq("s4_full_hold", {31'd0, board_full}, 32'd1);

        // Scenario 5: reset during CHECK aborts the move.
        do_reset();
        base_we = we_cnt;
        drop   = 1'b1;
        column = 4'b1110;
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("s5_async");
        drop = 1'b0;
        tick();
        tick();
        check_all_zero("s5_held");
        check_eq("s5_no_we", we_cnt - base_we, 32'd0);
        reset = 1'b0;
        tick();
        do_move(4'b1110, 0, 0, 0);

        // Scenario 6: column change after the latch is ignored.
        do_reset();
        drop   = 1'b1;
        column = 4'b1110;
        tick();
        column = 4'b0111;
        tick();
        check_eq("s6_we", {31'd0, place_we}, 32'd1);
        check_eq("s6_col", {30'd0, place_col}, 32'd0);
        check_eq("s6_row", {29'd0, place_row}, 32'd0);
        drop = 1'b0;
        tick();
        tick();
        check_eq("s6_count", {20'd0, count}, 32'h001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
